// File: rtl/sort_phase_sequencer.sv
// Handshaked controller for one odd-even transposition sort array: loads a row,
// walks SEND/RECV/CMP through every phase, then captures and offers the array maximum.
module sort_phase_sequencer #(
   parameter int ARRAYWIDTH  = 8,
   parameter int DATASIZE    = 16,
   parameter int SORT_PHASES = ARRAYWIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ARRAYWIDTH*DATASIZE-1:0] in_data,
   output logic [ARRAYWIDTH*DATASIZE-1:0] arr_data,
   output logic                           arr_write_enable,
   output logic                           odd_SL,
   output logic                           odd_SR,
   output logic                           odd_RL,
   output logic                           odd_RR,
   output logic                           even_SL,
   output logic                           even_SR,
   output logic                           even_RL,
   output logic                           even_RR,
   output logic                           odd_cmp_en,
   output logic                           even_cmp_en,
   input  logic [DATASIZE-1:0]            arr_max,
   output logic [DATASIZE-1:0]            max_out,
   output logic                           max_valid,
   input  logic                           max_ready,
   output logic                           busy,
   output logic [7:0]                     phase_idx
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SEND = 3'd2,
      S_RECV = 3'd3,
      S_CMP  = 3'd4,
      S_CAPT = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   localparam logic [7:0] LAST_PHASE = 8'(SORT_PHASES - 1);

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic [7:0]                       r_p;
   logic [7:0]                       w_p_nxt;
   logic                             w_grp_odd;
   logic [ARRAYWIDTH*DATASIZE-1:0]   r_arr_data;
   logic                             r_we;
   logic                             r_odd_send;
   logic                             r_odd_recv;
   logic                             r_even_send;
   logic                             r_even_recv;
   logic                             r_odd_cmp;
   logic                             r_even_cmp;
   logic [DATASIZE-1:0]              r_max_out;
   logic                             r_max_valid;

   // Next-state and phase-counter decode.
   always_comb begin
      w_state_nxt = r_state;
      w_p_nxt     = r_p;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = S_LOAD;
               w_p_nxt     = 8'd0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_SEND;
            w_p_nxt     = 8'd0;
         end
         S_SEND: w_state_nxt = S_RECV;
         S_RECV: w_state_nxt = S_CMP;
         S_CMP: begin
            if (r_p == LAST_PHASE) begin
               w_state_nxt = S_CAPT;
            end else begin
               w_state_nxt = S_SEND;
               w_p_nxt     = r_p + 8'd1;
            end
         end
         S_CAPT: w_state_nxt = S_OUT;
         S_OUT: begin
            if (max_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_OUT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_p_nxt     = 8'd0;
         end
      endcase
   end

   // Even phases drive the odd group, odd phases the even group.
   assign w_grp_odd = ~w_p_nxt[0];

   // State, counter and output registers; strobes are decoded from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_p         <= 8'd0;
         r_arr_data  <= '0;
         r_we        <= 1'b0;
         r_odd_send  <= 1'b0;
         r_odd_recv  <= 1'b0;
         r_even_send <= 1'b0;
         r_even_recv <= 1'b0;
         r_odd_cmp   <= 1'b0;
         r_even_cmp  <= 1'b0;
         r_max_out   <= '0;
         r_max_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_p         <= w_p_nxt;
         r_we        <= (w_state_nxt == S_LOAD);
         r_odd_send  <= (w_state_nxt == S_SEND) &&  w_grp_odd;
         r_odd_recv  <= (w_state_nxt == S_RECV) &&  w_grp_odd;
         r_odd_cmp   <= (w_state_nxt == S_CMP)  &&  w_grp_odd;
         r_even_send <= (w_state_nxt == S_SEND) && !w_grp_odd;
         r_even_recv <= (w_state_nxt == S_RECV) && !w_grp_odd;
         r_even_cmp  <= (w_state_nxt == S_CMP)  && !w_grp_odd;
         r_max_valid <= (w_state_nxt == S_OUT);
         if ((r_state == S_IDLE) && in_valid) begin
            r_arr_data <= in_data;
         end
         if (r_state == S_CAPT) begin
            r_max_out <= arr_max;
         end
      end
   end

   assign in_ready         = (r_state == S_IDLE);
   assign busy             = (r_state != S_IDLE);
   assign arr_data         = r_arr_data;
   assign arr_write_enable = r_we;
   assign odd_SL           = r_odd_send;
   assign odd_SR           = r_odd_send;
   assign odd_RL           = r_odd_recv;
   assign odd_RR           = r_odd_recv;
   assign even_SL          = r_even_send;
   assign even_SR          = r_even_send;
   assign even_RL          = r_even_recv;
   assign even_RR          = r_even_recv;
   assign odd_cmp_en       = r_odd_cmp;
   assign even_cmp_en      = r_even_cmp;
   assign max_out          = r_max_out;
   assign max_valid        = r_max_valid;
   assign phase_idx        = r_p;

endmodule

// File: tb/tb_sort_phase_sequencer.sv
// Directed bench for sort_phase_sequencer: default 8-wide instance plus a 4-wide, 4-phase variant.
module tb_sort_phase_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready;
   logic [127:0] in_data, arr_data;
   logic         arr_write_enable;
   logic         odd_SL, odd_SR, odd_RL, odd_RR, even_SL, even_SR, even_RL, even_RR;
   logic         odd_cmp_en, even_cmp_en;
   logic [15:0]  arr_max, max_out;
   logic         max_valid, max_ready, busy;
   logic [7:0]   phase_idx;

   logic         in_valid4, in_ready4;
   logic [63:0]  in_data4, arr_data4;
   logic         we4;
   logic         o_sl4, o_sr4, o_rl4, o_rr4, e_sl4, e_sr4, e_rl4, e_rr4, o_c4, e_c4;
   logic [15:0]  arr_max4, max_out4;
   logic         max_valid4, max_ready4, busy4;
   logic [7:0]   phase_idx4;

   logic [9:0]   strb, strb4;
   int           nvec = 0;
   int           nerr = 0;
   int           cyc = 0;

   always #5 clk = ~clk;

   sort_phase_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .arr_data(arr_data), .arr_write_enable(arr_write_enable),
      .odd_SL(odd_SL), .odd_SR(odd_SR), .odd_RL(odd_RL), .odd_RR(odd_RR),
      .even_SL(even_SL), .even_SR(even_SR), .even_RL(even_RL), .even_RR(even_RR),
      .odd_cmp_en(odd_cmp_en), .even_cmp_en(even_cmp_en), .arr_max(arr_max),
      .max_out(max_out), .max_valid(max_valid), .max_ready(max_ready),
      .busy(busy), .phase_idx(phase_idx)
   );

   sort_phase_sequencer #(.ARRAYWIDTH(4), .DATASIZE(16), .SORT_PHASES(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .arr_data(arr_data4), .arr_write_enable(we4),
      .odd_SL(o_sl4), .odd_SR(o_sr4), .odd_RL(o_rl4), .odd_RR(o_rr4),
      .even_SL(e_sl4), .even_SR(e_sr4), .even_RL(e_rl4), .even_RR(e_rr4),
      .odd_cmp_en(o_c4), .even_cmp_en(e_c4), .arr_max(arr_max4),
      .max_out(max_out4), .max_valid(max_valid4), .max_ready(max_ready4),
      .busy(busy4), .phase_idx(phase_idx4)
   );

   assign strb  = {odd_SL, odd_SR, odd_RL, odd_RR, even_SL, even_SR, even_RL, even_RR,
                   odd_cmp_en, even_cmp_en};
   assign strb4 = {o_sl4, o_sr4, o_rl4, o_rr4, e_sl4, e_sr4, e_rl4, e_rr4, o_c4, e_c4};

   task automatic tick();
      @(posedge clk);
      cyc = cyc + 1;
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec = nvec + 1;
      assert (obs === exp) else begin
         nerr = nerr + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe order {oSL,oSR,oRL,oRR,eSL,eSR,eRL,eRR,oCmp,eCmp}; step 0=send, 1=receive, 2=compare.
   function automatic logic [9:0] exp_strb(input int p, input int s);
      logic [9:0] v;
      v = 10'd0;
      if ((p % 2) == 0) begin
         if (s == 0) v = 10'b1100000000;
         else if (s == 1) v = 10'b0011000000;
         else v = 10'b0000000010;
      end else begin
         if (s == 0) v = 10'b0000110000;
         else if (s == 1) v = 10'b0000001100;
         else v = 10'b0000000001;
      end
      return v;
   endfunction

   initial begin
      logic [127:0] row1, row2, row3;
      logic [63:0]  row4;
      int e1 [8] = '{3, 7, 1, 9, 2, 8, 5, 4};
      int e2 [8] = '{16, 65535, 0, 12, 300, 7, 1, 2};
      int e3 [8] = '{66, 1, 2, 3, 4, 5, 6, 7};
      int e4 [4] = '{5, 2, 7, 1};
      int hs, hs_t [2], nhs, nres, nstrb, nmv, lat;
      logic [15:0] res [2];
      logic found;

      for (int k = 0; k < 8; k++) begin
         row1[k*16 +: 16] = 16'(e1[k]);
         row2[k*16 +: 16] = 16'(e2[k]);
         row3[k*16 +: 16] = 16'(e3[k]);
      end
      for (int k = 0; k < 4; k++) row4[k*16 +: 16] = 16'(e4[k]);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; arr_max = 16'd9; max_ready = 1'b0;
      in_valid4 = 1'b0; in_data4 = '0; arr_max4 = 16'd7; max_ready4 = 1'b1;
      tick(); tick();
      rst = 1'b0;

      chk("reset_outs", 128'({arr_write_enable, strb, max_valid, busy, max_out, phase_idx}), 128'd0);
      chk("reset_arr_data", arr_data, 128'd0);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_outs4", 128'({we4, strb4, max_valid4, busy4, max_out4, phase_idx4}), 128'd0);

      // Basic row, strobe ordering and output backpressure.
      in_data = row1; in_valid = 1'b1;
      chk("idle_in_ready", 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0; in_data = {8{16'hDEAD}};
      chk("load_in_ready", 128'(in_ready), 128'd0);
      chk("load_we", 128'(arr_write_enable), 128'd1);
      chk("load_arr_data", arr_data, row1);
      chk("load_busy", 128'(busy), 128'd1);
      nstrb = (strb != 10'd0) ? 1 : 0;
      for (int j = 0; j < 24; j++) begin
         tick();
         chk("strobes", 128'(strb), 128'(exp_strb(j / 3, j % 3)));
         chk("phase_idx", 128'(phase_idx), 128'(j / 3));
         chk("we_low", 128'(arr_write_enable), 128'd0);
         if (strb != 10'd0) nstrb = nstrb + 1;
      end
      tick();
      if (strb != 10'd0) nstrb = nstrb + 1;
      chk("capt_max_valid", 128'(max_valid), 128'd0);
      chk("strobe_cycles", 128'(nstrb), 128'd24);
      tick();
      chk("out_max_valid_27", 128'(max_valid), 128'd1);
      chk("out_max_out", 128'(max_out), 128'd9);
      arr_max = 16'h1234;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("bp_max_valid", 128'(max_valid), 128'd1);
         chk("bp_max_out", 128'(max_out), 128'd9);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      max_ready = 1'b1;
      tick();
      chk("rel_max_valid", 128'(max_valid), 128'd0);
      chk("rel_in_ready", 128'(in_ready), 128'd1);
      chk("hold_arr_data", arr_data, row1);

      // Back-to-back rows with in_valid and max_ready held high.
      in_data = row1; in_valid = 1'b1; nhs = 0; nres = 0;
      hs_t[0] = 0; hs_t[1] = 0; res[0] = 16'd0; res[1] = 16'd0;
      for (int i = 0; i < 120 && nres < 2; i++) begin
         if (in_valid && in_ready && nhs < 2) begin
            hs_t[nhs] = cyc + 1;
            nhs = nhs + 1;
            arr_max = (nhs == 1) ? 16'd9 : 16'hFFFF;
         end
         if (max_valid && max_ready) begin
            res[nres] = max_out;
            nres = nres + 1;
         end
         tick();
         if (nhs == 1) in_data = row2;
         if (nhs == 2) in_valid = 1'b0;
      end
      chk("b2b_handshakes", 128'(nhs), 128'd2);
      chk("b2b_spacing", 128'(hs_t[1] - hs_t[0]), 128'd28);
      chk("b2b_res0", 128'(res[0]), 128'd9);
      chk("b2b_res1", 128'(res[1]), 128'hFFFF);
      chk("b2b_arr_data", arr_data, row2);

      // Reset during phase 3 receive aborts the row.
      in_data = row1; arr_max = 16'd9; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 11; j++) tick();
      chk("p3_phase_idx", 128'(phase_idx), 128'd3);
      chk("p3_recv", 128'(strb), 128'(exp_strb(3, 1)));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_outs", 128'({arr_write_enable, strb, max_valid, busy, max_out, phase_idx}), 128'd0);
      chk("abort_arr_data", arr_data, 128'd0);
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      nmv = 0;
      for (int j = 0; j < 40; j++) begin
         tick();
         if (max_valid) nmv = nmv + 1;
      end
      chk("abort_no_result", 128'(nmv), 128'd0);
      in_data = row3; arr_max = 16'h0042; in_valid = 1'b1;
      hs = cyc + 1;
      tick();
      in_valid = 1'b0;
      found = 1'b0; lat = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (max_valid) begin
            found = 1'b1;
            lat = cyc + 1 - hs;
         end
      end
      chk("post_abort_latency", 128'(lat), 128'd27);
      chk("post_abort_max", 128'(max_out), 128'h42);

      // Four-wide, four-phase variant.
      in_data4 = row4; in_valid4 = 1'b1;
      hs = cyc + 1;
      tick();
      in_valid4 = 1'b0;
      chk("v4_we", 128'(we4), 128'd1);
      chk("v4_arr_data", 128'(arr_data4), 128'(row4));
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("v4_strobes", 128'(strb4), 128'(exp_strb(j / 3, j % 3)));
         chk("v4_phase_idx", 128'(phase_idx4), 128'(j / 3));
      end
      found = 1'b0; lat = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (max_valid4) begin
            found = 1'b1;
            lat = cyc + 1 - hs;
         end
      end
      chk("v4_latency", 128'(lat), 128'd15);
      chk("v4_max", 128'(max_out4), 128'd7);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/sort_phase_sequencer.md
Name: sort_phase_sequencer

Overview:
- Sequences one odd-even transposition sort array: accepts a row of ARRAYWIDTH elements from the output buffer, loads it into the array and steps through the odd/even compare-exchange phases.
- Drives the per-group send, receive and compare strobes, then captures the array's maximum and hands it to the softmax datapath.
- Sits between the output buffer (valid/ready source) and the sort array.
- Replaces free-running phase generation with a handshaked, one-row-at-a-time controller.

Parameters:
- ARRAYWIDTH, 8: elements per row; even, at least 4.
- DATASIZE, 16: bits per element, matching the output buffer data size.
- SORT_PHASES, ARRAYWIDTH: number of compare-exchange phases per row; 1 to 255.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  row available from the output buffer.
- in_ready  output  1  sequencer can accept a row.
- in_data  input  ARRAYWIDTH*DATASIZE  row; element k at bits [(k+1)*DATASIZE-1 : k*DATASIZE].
- arr_data  output  ARRAYWIDTH*DATASIZE  registered row driven to the array write ports.
- arr_write_enable  output  1  array load strobe.
- odd_SL, odd_SR, odd_RL, odd_RR  output  1 each  odd-group send-left, send-right, receive-left and receive-right strobes.
- even_SL, even_SR, even_RL, even_RR  output  1 each  even-group send and receive strobes.
- odd_cmp_en, even_cmp_en  output  1 each  group compare enables.
- arr_max  input  DATASIZE  array top-element output.
- max_out  output  DATASIZE  captured maximum.
- max_valid  output  1  max_out is valid.
- max_ready  input  1  consumer accepts max_out.
- busy  output  1  high in every state except IDLE.
- phase_idx  output  8  current phase number, for debug.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - While rst is high at a clock edge, the next state is IDLE.
  - All strobes, arr_write_enable, max_valid and busy are 0.
  - max_out, arr_data and phase_idx are 0.
  - Reset mid-sort aborts the row; no partial result is produced.
- Every output is registered, except in_ready and busy.
  - in_ready = (state==IDLE).
  - busy = (state!=IDLE).
- States: IDLE, LOAD, SEND, RECV, CMP, CAPT, OUT.
- IDLE:
  - in_valid && in_ready at an edge captures in_data into arr_data and goes to LOAD.
  - in_valid without the handshake changes nothing.
- LOAD (1 cycle):
  - arr_write_enable=1.
  - Clears the phase counter p to 0; next state is SEND.
- Each phase p is three cycles: SEND, RECV, CMP.
  - p even uses the odd group; p odd uses the even group.
  - SEND: the group's SL and SR are 1.
  - RECV: the group's RL and RR are 1.
  - CMP: the group's cmp_en is 1.
  - Only the active group's strobes are ever asserted; at most one strobe class (send, receive or compare) is high in any cycle.
  - phase_idx = p throughout the phase.
- From CMP:
  - If p==SORT_PHASES-1, go to CAPT.
  - Otherwise p increments and the next state is SEND.
- CAPT (1 cycle): all strobes 0; registers arr_max into max_out; next state is OUT.
- OUT:
  - max_valid=1; max_out is held stable until max_ready is sampled high.
  - On max_valid && max_ready: max_valid drops to 0 and the next state is IDLE.
  - in_ready is 0 in OUT, so a new row is never accepted in the same cycle as result consumption.
- Timing from an input handshake at edge E:
  - arr_write_enable is high in cycle E+1.
  - Phase p occupies cycles E+2+3p, E+3+3p and E+4+3p.
  - CAPT is cycle E+3*SORT_PHASES+2.
  - max_valid rises at E+3*SORT_PHASES+3; for the defaults that is E+27.
- Back-to-back rows: the minimum spacing between input handshakes is 3*SORT_PHASES+4 cycles when max_ready is held high.
- arr_data holds the captured row until the next input handshake.
- in_data is ignored outside the handshake.
- Phase counter width is 8 bits; it never wraps because SORT_PHASES is at most 255.

Test Plan:
- Basic row: rst for 2 cycles, then in_data elements = {3,7,1,9,2,8,5,4} (k=0..7), with the array model returning 9 on arr_max.
  - in_ready drops the cycle after the handshake.
  - arr_write_enable is high exactly one cycle.
  - max_valid rises 27 cycles after the handshake, with max_out=9.
- Strobe ordering: same row; check per cycle.
  - The odd group is active in phases 0,2,4,6 and the even group in phases 1,3,5,7.
  - Strobe order within each phase is SL/SR, then RL/RR, then cmp_en.
  - There are 24 strobe cycles in total with no overlap; phase_idx counts 0..7.
- Output backpressure: hold max_ready=0 for 10 cycles after max_valid rises.
  - max_out stays at 9 and in_ready stays 0.
  - Then pulse max_ready: max_valid is 0 on the next cycle and in_ready is 1.
- Back-to-back: hold in_valid=1 with max_ready=1 and two rows with maxima 9 then 0xFFFF.
  - The second handshake occurs exactly 28 cycles after the first.
  - Results arrive in order: 9, then 0xFFFF.
- Reset mid-sort: assert rst during phase 3 RECV.
  - On the next cycle all outputs are 0 and in_ready=1.
  - max_valid never rises for the aborted row.
  - A following row sorts normally.
- Parameter variant: SORT_PHASES=4, ARRAYWIDTH=4.
  - max_valid rises 15 cycles after the handshake.
  - phase_idx counts 0..3; odd, even, odd, even group order.
